// File: rtl/img_col_feeder_if.sv
// Bus bundle between the column feeder, its pixel memory and the downstream window register.
interface img_col_feeder_if #(
    parameter int AW  = 16,
    parameter int K_H = 3
);
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_addr;
    logic [7:0]            mem_rdata;
    logic [K_H-1:0][7:0]   col_data;
    logic                  col_load;
    logic                  col_clear;
    logic                  col_ready;
    logic                  win_valid;

    modport master (
        output mem_rd_en, mem_addr, col_data, col_load, col_clear, win_valid,
        input  mem_rdata, col_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, col_data, col_load, col_clear, win_valid,
        output mem_rdata, col_ready
    );
endinterface

// File: rtl/img_col_feeder.sv
// Walks an image band by band, reading K_H pixels per column and handing each
// assembled column to a circular window register with a ready/load handshake.
module img_col_feeder #(
    parameter int IMG_H = 8,
    parameter int IMG_W = 8,
    parameter int K_H   = 3,
    parameter int K_W   = 3,
    parameter int AW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    img_col_feeder_if.master  bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H - K_H + 1 > 1) ? $clog2(IMG_H - K_H + 1) : 1;
    localparam int FW = (K_H > 1) ? $clog2(K_H) : 1;

    typedef enum logic [2:0] {IDLE, CLR, FETCH, WAIT, EMIT, FIN} state_t;

    state_t               state;
    logic [RW-1:0]        band_row;
    logic [CW-1:0]        col;
    logic [FW-1:0]        fetch_idx;
    logic [AW-1:0]        row_base;
    logic                 rd_pend;
    logic [FW-1:0]        rd_idx;
    logic                 mem_rd_en;
    logic [AW-1:0]        mem_addr;
    logic [K_H-1:0][7:0]  col_data;
    logic                 col_clear;
    logic                 col_load;

    // The load must follow col_ready in the same cycle, so it is decoded from state.
    assign col_load      = (state == EMIT) && bus.col_ready;
    assign bus.col_load  = col_load;
    assign bus.win_valid = col_load && (col >= CW'(K_W - 1));
    assign bus.mem_rd_en = mem_rd_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.col_data  = col_data;
    assign bus.col_clear = col_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            band_row  <= '0;
            col       <= '0;
            fetch_idx <= '0;
            row_base  <= '0;
            rd_pend   <= 1'b0;
            rd_idx    <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            col_data  <= '0;
            col_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            col_clear <= 1'b0;

            // Read data returns one cycle after issue; track which element it belongs to.
            if (rd_pend)
                col_data[rd_idx] <= bus.mem_rdata;
            rd_pend <= mem_rd_en;
            rd_idx  <= fetch_idx;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLR;
                        busy      <= 1'b1;
                        col_clear <= 1'b1;
                        band_row  <= '0;
                        col       <= '0;
                        row_base  <= '0;
                    end
                end
                CLR: begin
                    state     <= FETCH;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= row_base + AW'(col);
                    fetch_idx <= '0;
                end
                FETCH: begin
                    if (fetch_idx == FW'(K_H - 1)) begin
                        state     <= WAIT;
                        mem_rd_en <= 1'b0;
                    end else begin
                        fetch_idx <= fetch_idx + FW'(1);
                        mem_addr  <= mem_addr + AW'(IMG_W);
                    end
                end
                WAIT: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (bus.col_ready) begin
                        if (col != CW'(IMG_W - 1)) begin
                            col       <= col + CW'(1);
                            state     <= FETCH;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= row_base + AW'(col) + AW'(1);
                            fetch_idx <= '0;
                        end else if (band_row != RW'(IMG_H - K_H)) begin
                            band_row  <= band_row + RW'(1);
                            col       <= '0;
                            row_base  <= row_base + AW'(IMG_W);
                            state     <= CLR;
                            col_clear <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_img_col_feeder.sv
// Scoreboard bench: a 4x4 and a 3x3 image feeder, each with a pixel=address memory.
module tb_img_col_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    always #5 clk = ~clk;

    img_col_feeder_if #(.AW(16), .K_H(3)) bus_a ();
    img_col_feeder_if #(.AW(16), .K_H(3)) bus_b ();

    img_col_feeder #(.IMG_H(4), .IMG_W(4), .K_H(3), .K_W(3), .AW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
    );
    img_col_feeder #(.IMG_H(3), .IMG_W(3), .K_H(3), .K_W(3), .AW(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    // Pixel memory: value = low byte of address, one cycle read latency.
    always @(posedge clk) begin
        bus_a.mem_rdata <= bus_a.mem_rd_en ? bus_a.mem_addr[7:0] : 8'hEE;
        bus_b.mem_rdata <= bus_b.mem_rd_en ? bus_b.mem_addr[7:0] : 8'hEE;
    end

    typedef struct {
        logic [23:0] data;
        logic        wv;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int loads_a = 0, clears_a = 0, wv_a = 0, dones_a = 0, last_a = -10;
    int loads_b = 0, clears_b = 0, wv_b = 0, dones_b = 0, last_b = -10;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Expected columns for the 4x4 image: element i = (band+i)*4 + col.
    task automatic push_a(input int nbands);
        exp_t e;
        for (int b = 0; b < nbands; b++)
            for (int c = 0; c < 4; c++) begin
                e.data = {8'((b + 2) * 4 + c), 8'((b + 1) * 4 + c), 8'(b * 4 + c)};
                e.wv   = (c >= 2);
                qa.push_back(e);
            end
    endtask

    task automatic push_b();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            e.data = {8'(6 + c), 8'(3 + c), 8'(c)};
            e.wv   = (c == 2);
            qb.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every load and checks strobe relationships.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus_a.col_load) begin
            loads_a++;
            last_a = cyc;
            if (bus_a.win_valid) wv_a++;
            chk("a_load_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_col_data", 32'(bus_a.col_data), 32'(e.data));
                chk("a_win_valid", 32'(bus_a.win_valid), 32'(e.wv));
            end
        end
        if (bus_a.win_valid) chk("a_wv_with_load", 32'(bus_a.col_load), 32'd1);
        if (bus_a.col_clear) begin
            clears_a++;
            chk("a_clear_load_overlap", 32'(bus_a.col_load), 32'd0);
        end
        if (done_a) begin
            dones_a++;
            chk("a_done_after_last_load", 32'(cyc), 32'(last_a + 1));
        end
        if (bus_b.col_load) begin
            loads_b++;
            last_b = cyc;
            if (bus_b.win_valid) wv_b++;
            chk("b_load_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_col_data", 32'(bus_b.col_data), 32'(e.data));
                chk("b_win_valid", 32'(bus_b.win_valid), 32'(e.wv));
            end
        end
        if (bus_b.col_clear) begin
            clears_b++;
            chk("b_clear_load_overlap", 32'(bus_b.col_load), 32'd0);
        end
        if (done_b) begin
            dones_b++;
            chk("b_done_after_last_load", 32'(cyc), 32'(last_b + 1));
        end
    end

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string nm);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_a_idle(input string nm);
        chk({nm, "_busy"},      32'(busy_a),          32'd0);
        chk({nm, "_done"},      32'(done_a),          32'd0);
        chk({nm, "_rd_en"},     32'(bus_a.mem_rd_en), 32'd0);
        chk({nm, "_addr"},      32'(bus_a.mem_addr),  32'd0);
        chk({nm, "_load"},      32'(bus_a.col_load),  32'd0);
        chk({nm, "_clear"},     32'(bus_a.col_clear), 32'd0);
        chk({nm, "_win_valid"}, 32'(bus_a.win_valid), 32'd0);
        chk({nm, "_col_data"},  32'(bus_a.col_data),  32'd0);
    endtask

    initial begin
        int l0, c0, w0, d0;
        logic seen;
        bus_a.col_ready = 1'b1;
        bus_b.col_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a_idle("reset");
        chk("reset_busy_b", 32'(busy_b), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full 4x4 frame, with a second start mid-frame that must be ignored
        l0 = loads_a; c0 = clears_a; w0 = wv_a; d0 = dones_a;
        push_a(2);
        pulse_start_a();
        @(negedge clk);
        chk("start_busy", 32'(busy_a), 32'd1);
        chk("start_clear", 32'(bus_a.col_clear), 32'd1);
        repeat (12) @(posedge clk);
        pulse_start_a();
        wait_done_a("frame1_done_seen");
        chk("frame1_loads", 32'(loads_a - l0), 32'd8);
        chk("frame1_clears", 32'(clears_a - c0), 32'd2);
        chk("frame1_win_valid", 32'(wv_a - w0), 32'd4);
        chk("frame1_dones", 32'(dones_a - d0), 32'd1);
        chk("frame1_queue_empty", 32'(qa.size()), 32'd0);
        chk("frame1_idle_busy", 32'(busy_a), 32'd0);

        // Backpressure on the first column
        l0 = loads_a;
        push_a(2);
        bus_a.col_ready = 1'b0;
        pulse_start_a();
        repeat (5) @(posedge clk);
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            chk("stall_load", 32'(bus_a.col_load), 32'd0);
            chk("stall_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
            chk("stall_col_data", 32'(bus_a.col_data), 32'h080400);
        end
        @(posedge clk); #1 bus_a.col_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_load", 32'(bus_a.col_load), 32'd1);
        wait_done_a("frame2_done_seen");
        chk("frame2_loads", 32'(loads_a - l0), 32'd8);
        chk("frame2_queue_empty", 32'(qa.size()), 32'd0);

        // Abort during band 1 fetch, with start held alongside reset
        l0 = loads_a; d0 = dones_a;
        push_a(1);
        pulse_start_a();
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (bus_a.col_clear && !busy_a) seen = 1'b0;
            else if (bus_a.col_clear && (loads_a - l0) == 4) seen = 1'b1;
        end
        chk("abort_band1_clear_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("band1_first_rd_en", 32'(bus_a.mem_rd_en), 32'd1);
        chk("band1_first_addr", 32'(bus_a.mem_addr), 32'd4);
        rst = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check_a_idle("abort");
        #1;
        chk("abort_loads", 32'(loads_a - l0), 32'd4);
        chk("abort_no_done", 32'(dones_a - d0), 32'd0);
        chk("abort_queue_empty", 32'(qa.size()), 32'd0);

        // Fresh frame after abort starts at band 0, address 0
        l0 = loads_a;
        push_a(2);
        pulse_start_a();
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus_a.mem_rd_en) seen = 1'b1;
        end
        chk("restart_rd_seen", 32'(seen), 32'd1);
        chk("restart_first_addr", 32'(bus_a.mem_addr), 32'd0);
        wait_done_a("frame3_done_seen");
        chk("frame3_loads", 32'(loads_a - l0), 32'd8);

        // Minimal 3x3 image: single band
        push_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        chk("b_done_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        chk("b_loads", 32'(loads_b), 32'd3);
        chk("b_clears", 32'(clears_b), 32'd1);
        chk("b_win_valid", 32'(wv_b), 32'd1);
        chk("b_dones", 32'(dones_b), 32'd1);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/img_col_feeder.md
IMG_COL_FEEDER -- requirements
Module: img_col_feeder

Interface
REQ-001 Parameter IMG_H, default 8, image height in pixels (IMG_H >= K_H).
REQ-002 Parameter IMG_W, default 8, image width in pixels (IMG_W >= K_W).
REQ-003 Parameter K_H, default 3, kernel height (window rows delivered per column).
REQ-004 Parameter K_W, default 3, kernel width (columns per full window).
REQ-005 Parameter AW, default 16, pixel memory address width.
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse that begins a frame; ignored unless idle.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse after the last column of the last band is emitted.
REQ-011 mem_rd_en  output  1  pixel memory read strobe.
REQ-012 mem_addr  output  AW  pixel address, row-major: row*IMG_W + col.
REQ-013 mem_rdata  input  8  pixel data, valid exactly 1 cycle after mem_rd_en.
REQ-014 col_data  output  8 x K_H  assembled column; element i = pixel (band_row+i, col).
REQ-015 col_load  output  1  load strobe to the circular window register; col_data valid.
REQ-016 col_clear  output  1  one-cycle clear strobe to the window register at each band start.
REQ-017 col_ready  input  1  downstream may accept a column this cycle.
REQ-018 win_valid  output  1  with col_load: window holds K_W valid columns after this load.

Function
REQ-019 FSM states: IDLE, CLR, FETCH, WAIT, EMIT, FIN; reset enters IDLE.
REQ-020 IDLE + start -> CLR; band_row = 0, col = 0.
REQ-021 CLR: col_clear = 1 for exactly one cycle -> FETCH.
REQ-022 FETCH: K_H consecutive cycles, mem_rd_en = 1, mem_addr = (band_row+i)*IMG_W + col for i = 0..K_H-1 -> WAIT.
REQ-023 Read data captured into col_data[i] the cycle after issue i; WAIT lasts one cycle to capture the last element -> EMIT.
REQ-024 EMIT: col_load = col_ready; col_data held stable while col_ready = 0; no memory reads issued.
REQ-025 On col_load: win_valid = 1 iff col >= K_W-1.
REQ-026 After load, col < IMG_W-1: col++ -> FETCH.
REQ-027 After load, col = IMG_W-1 and band_row < IMG_H-K_H: band_row++, col = 0 -> CLR.
REQ-028 After load, col = IMG_W-1 and band_row = IMG_H-K_H -> FIN; FIN pulses done for one cycle -> IDLE.
REQ-029 Bands per frame = IMG_H-K_H+1; columns per band = IMG_W; total col_load pulses = (IMG_H-K_H+1)*IMG_W.
REQ-030 Minimum cycles per column = K_H+2 (col_ready held high).
REQ-031 start while busy is ignored; no restart, no counter change.
REQ-032 col_load and col_clear never asserted in the same cycle.
REQ-033 mem_addr computed at full AW width; no wrap for IMG_H*IMG_W <= 2^AW (designer-guaranteed).
REQ-034 busy = 1 in CLR, FETCH, WAIT, EMIT, FIN; 0 in IDLE.

Reset
REQ-035 rst = 1 at a clock edge: state -> IDLE; band_row, col, fetch index -> 0; col_data -> all 0.
REQ-036 Reset values: busy, done, mem_rd_en, col_load, col_clear, win_valid = 0; mem_addr = 0.
REQ-037 rst mid-frame aborts immediately; no done pulse; next start begins a fresh frame at band 0.
REQ-038 rst has priority over start in the same cycle.

Verification
REQ-039 IMG_H=4, IMG_W=4, K=3, memory pixel = addr, col_ready=1: start -> 8 col_load pulses; band 0 col 0 col_data = {0,4,8}; band 1 col 3 = {7,11,15}; done 1 cycle after last load; 2 col_clear pulses.
REQ-040 Same config: win_valid on loads at col 2 and col 3 of each band only (4 total).
REQ-041 col_ready low 5 cycles during first EMIT: col_load held 0, col_data stable, mem_rd_en 0; load occurs the cycle col_ready rises; final load count still 8.
REQ-042 rst asserted during band 1 FETCH: next cycle all outputs 0, state IDLE; new start -> first mem_addr = 0.
REQ-043 start pulsed again mid-frame: ignored; load sequence and count identical to REQ-039.
REQ-044 IMG_H=K_H=3, IMG_W=3: exactly 3 loads, 1 col_clear, win_valid only on third load, then done.
